// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU simulation harnesses: sequences core reset, counts run cycles,
// watches per-core offload flags and ends the run as done or timed out.
module cpu_run_ctrl #(
   parameter int NUM_CORES      = 2,
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_WIDTH      = 32,
   parameter int WAIT_ALL       = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_CORES-1:0]           offload,
   output logic                           core_reset,
   output logic                           running,
   output logic                           done,
   output logic                           timeout,
   output logic [NUM_CORES-1:0]           offload_mask,
   output logic [CNT_WIDTH-1:0]           cycle_count,
   output logic [NUM_CORES*CNT_WIDTH-1:0] offload_cycle
);

   localparam int                   HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_HOLD,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_e;

   state_e                         state_q, state_d;
   logic [HOLD_W-1:0]              hold_q, hold_d;
   logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
   logic [NUM_CORES-1:0]           mask_q, mask_d;
   logic [NUM_CORES*CNT_WIDTH-1:0] ocyc_q, ocyc_d;
   logic                           core_reset_q, core_reset_d;
   logic                           running_q, running_d;
   logic                           done_q, done_d;
   logic                           timeout_q, timeout_d;
   logic [NUM_CORES-1:0]           next_mask;
   logic                           done_cond;

   always_comb begin
      // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      ocyc_d    = ocyc_q;
      next_mask = mask_q | offload;
      done_cond = (WAIT_ALL != 0) ? (&next_mask) : (|next_mask);

      unique case (state_q)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            if (start) begin
               state_d = S_RST_HOLD;
               hold_d  = '0;
               cnt_d   = '0;
               mask_d  = '0;
               ocyc_d  = '0;
            end
         end
         S_RST_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
            else                     hold_d  = hold_q + 1'b1;
         end
         S_RUN: begin
            // The edge leaving RUN still counts, so the frozen count is one past the final cycle.
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            mask_d = next_mask;
            for (int i = 0; i < NUM_CORES; i++) begin
               if (offload[i] && !mask_q[i]) ocyc_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
            end
            if (done_cond)                                       state_d = S_DONE;
            else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) state_d = S_TIMEOUT;
         end
         default: state_d = S_IDLE;
      endcase

      // Flags decode the next state so they are registered alongside it.
      core_reset_d = (state_d == S_IDLE) || (state_d == S_RST_HOLD);
      running_d    = (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      timeout_d    = (state_d == S_TIMEOUT);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         cnt_q        <= '0;
         mask_q       <= '0;
         ocyc_q       <= '0;
         core_reset_q <= 1'b1;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         ocyc_q       <= ocyc_d;
         core_reset_q <= core_reset_d;
         running_q    <= running_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign core_reset    = core_reset_q;
   assign running       = running_q;
   assign done          = done_q;
   assign timeout       = timeout_q;
   assign offload_mask  = mask_q;
   assign cycle_count   = cnt_q;
   assign offload_cycle = ocyc_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequential run controller for CPU simulation harnesses and multi-core bring-up.
- Sequences core reset, counts run cycles, and watches the `offload` (program-end) flag of NUM_CORES cores.
- Declares completion in all-cores or any-core mode, or declares a timeout.
- Latches the per-core cycle at which each core offloaded, so a bench or top level can end the run and report without ad-hoc `always @(offload)` logic.

Parameters:
- NUM_CORES, 2, number of monitored cores / offload inputs (>=1).
- RESET_CYCLES, 2, cycles core_reset is held after start (>=1).
- TIMEOUT_CYCLES, 1000, run cycles before timeout; 0 disables timeout.
- CNT_WIDTH, 32, width of all cycle counters.
- WAIT_ALL, 1, 1 = done when every core has offloaded; 0 = done on first offload.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request; honoured only in IDLE, DONE, TIMEOUT.
- offload  in  NUM_CORES  per-core program-end flags (level).
- core_reset  out  1  reset driven to the cores.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in TIMEOUT.
- offload_mask  out  NUM_CORES  sticky record of which cores have offloaded this run.
- cycle_count  out  CNT_WIDTH  run cycles elapsed.
- offload_cycle  out  NUM_CORES*CNT_WIDTH  cycle_count captured at each core's first offload; core i occupies slice [i*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, core_reset=1, running=0, done=0, timeout=0, offload_mask=0, cycle_count=0, offload_cycle=0.
- Reset mid-run overrides everything: the next edge returns all of the above.
- FSM states: IDLE, RST_HOLD, RUN, DONE, TIMEOUT. All outputs are registered.
- IDLE:
  - core_reset=1.
  - start=1 -> RST_HOLD; clears offload_mask, offload_cycle, cycle_count and the hold counter.
- RST_HOLD:
  - core_reset=1 for exactly RESET_CYCLES cycles, then -> RUN.
  - start is ignored.
- RUN:
  - core_reset=0, running=1.
  - cycle_count=0 on the first RUN cycle; +1 each RUN cycle; saturates at all-ones with no wrap.
  - offload is sampled only in RUN. Offload during IDLE or RST_HOLD is ignored, as are stale flags while the cores are held in reset.
  - New offload on core i (offload[i]=1, mask[i]=0) in a cycle where cycle_count=k: mask[i]<=1 and offload_cycle slice i<=k.
  - Later offload values on core i are ignored: the mask is sticky, and deassertion does not clear it.
  - The done condition is evaluated on the next-mask value (mask | offload):
    - WAIT_ALL=1: all bits set.
    - WAIT_ALL=0: any bit set.
  - Done condition true -> DONE next edge.
  - Else, if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT next edge.
  - Done and timeout on the same cycle: done wins.
  - start is ignored.
- DONE / TIMEOUT:
  - Terminal; core_reset=0 so core state stays inspectable.
  - cycle_count, offload_mask and offload_cycle are frozen.
  - done or timeout is held high until start or reset.
  - start=1 -> RST_HOLD with the same clears as from IDLE.
- Outputs done, timeout and running are mutually exclusive at all times.

Test Plan:
- NUM_CORES=2, WAIT_ALL=1, RESET_CYCLES=2: start pulse -> core_reset high 2 cycles after RST_HOLD entry. offload[0] at cycle_count=5, offload[1] at 9 -> offload_cycle={9,5}, done=1 one cycle later, cycle_count frozen at 10.
- WAIT_ALL=0, offload[1] at cycle_count=3 -> done next edge; offload_mask=2'b10; offload_cycle slice1=3, slice0=0.
- TIMEOUT_CYCLES=20, no offload -> timeout=1 after cycle_count reaches 19; done=0, running=0.
- Both offloads arrive at cycle_count=19 with TIMEOUT_CYCLES=20 -> done=1, timeout=0.
- offload held high during RST_HOLD, then dropped before RUN -> mask stays 0. Offload pulsing on/off in RUN -> offload_cycle records the first edge only.
- reset asserted at cycle_count=7 in RUN -> next edge IDLE, core_reset=1, all counters/masks 0. start in DONE -> fresh run with cycle_count restarting at 0.
